apb_mem_s: RTL and testbench

//  APB completer (slave) counterpart to the team's APB BFM initiator: word-addressed
//  on-chip SRAM model with parameterised wait states, PREADY/PSLVERR response and

---
 rtl/apb_mem_s_if.sv | 31 +++
 rtl/apb_mem_s.sv | 136 +++++++++++++
 tb/tb_apb_mem_s.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_s_if.sv
// APB completer bus bundle for apb_mem_s.
// PSTRB exists only when APB_MEM_STRB_EN is defined.
interface apb_mem_s_if;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
`ifdef APB_MEM_STRB_EN
   logic [3:0]  PSTRB;
`endif
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
`ifdef APB_MEM_STRB_EN
      output PSTRB,
`endif
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
`ifdef APB_MEM_STRB_EN
      input  PSTRB,
`endif
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_mem_s.sv
// APB completer SRAM model with per-direction wait states and range/alignment errors.
// Define APB_MEM_STRB_EN to enable PSTRB byte-lane writes (default: full-word writes).
module apb_mem_s #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned WAIT_RD    = 0,
   parameter int unsigned WAIT_WR    = 0
) (
   input logic        PCLK,
   input logic        PRESETn,
   apb_mem_s_if.slave bus
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            strb_q, strb_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  goReady;

   logic [31:0]           mem [DEPTH];

   logic [31:0]           off;
   logic                  decErr;
   logic [DEPTH_LOG2-1:0] decIdx;
   logic [3:0]            waitSel;
   logic [3:0]            setupStrb;

   assign off     = bus.PADDR - BASE_ADDR;
   assign decErr  = (bus.PADDR < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH))
                    || (bus.PADDR[1:0] != 2'b00);
   assign decIdx  = off[DEPTH_LOG2+1:2];
   assign waitSel = bus.PWRITE ? 4'(WAIT_WR) : 4'(WAIT_RD);

`ifdef APB_MEM_STRB_EN
   assign setupStrb = bus.PSTRB;
`else
   assign setupStrb = 4'hF;
`endif

   // Everything about the transfer is captured in SETUP; later bus changes are ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      err_d   = err_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      rdata_d = '0;
      goReady = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.PSEL && !bus.PENABLE) begin
               idx_d   = decIdx;
               write_d = bus.PWRITE;
               err_d   = decErr;
               wdata_d = bus.PWDATA;
               strb_d  = setupStrb;
               cnt_d   = waitSel;
               if (waitSel == 4'd0) begin
                  state_d = READY;
                  goReady = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!bus.PSEL) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus.PENABLE) begin
               if (cnt_q <= 4'd1) begin
                  state_d = READY;
                  goReady = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         READY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Read data is fetched on entry to READY so PRDATA is a plain register.
      if (goReady && !write_d && !err_d) begin
         rdata_d = mem[idx_d];
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         err_q   <= err_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
      end
   end

   // Array is deliberately not reset; reset forces IDLE so an in-flight write never lands.
   always_ff @(posedge PCLK) begin
      if (state_q == READY && write_q && !err_q) begin
         for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) begin
               mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign bus.PREADY  = (state_q == READY);
   assign bus.PSLVERR = (state_q == READY) && err_q;
   assign bus.PRDATA  = rdata_q;

endmodule

// File: tb/tb_apb_mem_s.sv
// Scoreboard bench for apb_mem_s: three instances with different wait/base settings
// share one bus driver; expected responses are queued as each transfer is launched.
module tb_apb_mem_s;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic [7:0]  lat;
   } resp_t;

   logic        clk = 1'b0;
   logic        rstN = 1'b1;
   logic [1:0]  sel = 2'd0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = 4'hF;

   int checks = 0;
   int passes = 0;

   resp_t expQ[$];
   resp_t gotQ[$];
   string nameQ[$];

   always #5 clk = ~clk;

   apb_mem_s_if bus[3] ();

   logic [2:0]  readyV;
   logic [2:0]  errV;
   logic [31:0] rdataV [3];

   for (genvar g = 0; g < 3; g++) begin : gDrv
      assign bus[g].PSEL    = psel && (sel == 2'(g));
      assign bus[g].PENABLE = penable;
      assign bus[g].PADDR   = paddr;
      assign bus[g].PWRITE  = pwrite;
      assign bus[g].PWDATA  = pwdata;
`ifdef APB_MEM_STRB_EN
      assign bus[g].PSTRB   = pstrb;
`endif
      assign readyV[g] = bus[g].PREADY;
      assign errV[g]   = bus[g].PSLVERR;
      assign rdataV[g] = bus[g].PRDATA;
   end

   logic        mReady;
   logic        mErr;
   logic [31:0] mRdata;
   assign mReady = readyV[sel];
   assign mErr   = errV[sel];
   assign mRdata = rdataV[sel];

   apb_mem_s #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000), .WAIT_RD(0), .WAIT_WR(0))
      dut0 (.PCLK(clk), .PRESETn(rstN), .bus(bus[0]));
   apb_mem_s #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0001_0000), .WAIT_RD(2), .WAIT_WR(5))
      dut1 (.PCLK(clk), .PRESETn(rstN), .bus(bus[1]));
   apb_mem_s #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000), .WAIT_RD(0), .WAIT_WR(3))
      dut2 (.PCLK(clk), .PRESETn(rstN), .bus(bus[2]));

   localparam logic [31:0] B1 = 32'h0001_0000;

   task automatic expectResp(input string nm, input logic [31:0] d, input logic e, input int lat);
      resp_t r;
      r.data = d;
      r.err  = e;
      r.lat  = 8'(lat);
      expQ.push_back(r);
      nameQ.push_back(nm);
   endtask

   // lat = index of the ACCESS cycle carrying PREADY; address/data are scrambled after SETUP.
   task automatic applyStimulus(input logic [1:0] dutSel, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb);
      resp_t got;
      int    n;
      @(posedge clk); #1;
      sel = dutSel; psel = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge clk); #1;
      penable = 1'b1; paddr = 32'hFFFF_FFFC; pwdata = ~data; pstrb = ~strb;
      got.data = 'x;
      got.err  = 1'bx;
      got.lat  = 8'hFF;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (mReady) begin
            got.data = mRdata;
            got.err  = mErr;
            got.lat  = 8'(n);
            break;
         end
      end
      if (got.lat == 8'hFF) begin
         psel = 1'b0; penable = 1'b0;
      end
      gotQ.push_back(got);
   endtask

   task automatic idleBus();
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      resp_t exp, got;
      string nm;
      #2 rstN = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({readyV[g], errV[g], rdataV[g]} !== 34'b0)
            $display("[TB] FAIL reset_out%0d got ready=%b err=%b rdata=%h want all 0", g, readyV[g], errV[g], rdataV[g]);
         else passes++;
      end
      @(negedge clk); rstN = 1'b1;
      expectResp("rst_prewrite", 32'h0, 1'b0, 4);
      applyStimulus(2'd2, 1'b1, 32'h20, 32'hCAFE_0001, 4'hF);
      idleBus();
      @(posedge clk); #1;
      sel = 2'd2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #3;
      rstN = 1'b0;
      #1;
      checks++;
      if ({mReady, mErr, mRdata} !== 34'b0)
         $display("[TB] FAIL rst_midwait got ready=%b err=%b rdata=%h want all 0", mReady, mErr, mRdata);
      else passes++;
      repeat (2) @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0;
      @(negedge clk); rstN = 1'b1;
      expectResp("rst_readback", 32'hCAFE_0001, 1'b0, 1);
      applyStimulus(2'd2, 1'b0, 32'h20, 32'h0, 4'hF);
      idleBus();
      while (expQ.size() > 0) begin
         exp = expQ.pop_front(); got = gotQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (got !== exp)
            $display("[TB] FAIL %s got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                     nm, got.data, got.err, got.lat, exp.data, exp.err, exp.lat);
         else passes++;
      end
   endtask

   task automatic test_zero_wait();
      resp_t exp, got;
      string nm;
      expectResp("zw_wr10",  32'h0,         1'b0, 1); applyStimulus(2'd0, 1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF);
      expectResp("zw_rd10",  32'hDEAD_BEEF, 1'b0, 1); applyStimulus(2'd0, 1'b0, 32'h10,  32'h0,         4'hF);
      expectResp("zw_wr0",   32'h0,         1'b0, 1); applyStimulus(2'd0, 1'b1, 32'h0,   32'h0000_5A5A, 4'hF);
      expectResp("zw_wrTop", 32'h0,         1'b0, 1); applyStimulus(2'd0, 1'b1, 32'hFFC, 32'h8000_0001, 4'hF);
      expectResp("zw_rdTop", 32'h8000_0001, 1'b0, 1); applyStimulus(2'd0, 1'b0, 32'hFFC, 32'h0,         4'hF);
      expectResp("zw_rd0",   32'h0000_5A5A, 1'b0, 1); applyStimulus(2'd0, 1'b0, 32'h0,   32'h0,         4'hF);
      idleBus();
      while (expQ.size() > 0) begin
         exp = expQ.pop_front(); got = gotQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (got !== exp)
            $display("[TB] FAIL %s got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                     nm, got.data, got.err, got.lat, exp.data, exp.err, exp.lat);
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      resp_t exp, got;
      string nm;
      expectResp("wt_wr40",  32'h0,         1'b0, 6); applyStimulus(2'd1, 1'b1, B1 + 32'h40,  32'h0BAD_F00D, 4'hF);
      expectResp("wt_rd40",  32'h0BAD_F00D, 1'b0, 3); applyStimulus(2'd1, 1'b0, B1 + 32'h40,  32'h0,         4'hF);
      expectResp("wt_wrTop", 32'h0,         1'b0, 6); applyStimulus(2'd1, 1'b1, B1 + 32'hFFC, 32'h1357_9BDF, 4'hF);
      expectResp("wt_rdTop", 32'h1357_9BDF, 1'b0, 3); applyStimulus(2'd1, 1'b0, B1 + 32'hFFC, 32'h0,         4'hF);
      idleBus();
      while (expQ.size() > 0) begin
         exp = expQ.pop_front(); got = gotQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (got !== exp)
            $display("[TB] FAIL %s got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                     nm, got.data, got.err, got.lat, exp.data, exp.err, exp.lat);
         else passes++;
      end
   endtask

   task automatic test_errors();
      resp_t exp, got;
      string nm;
      expectResp("er_wr0",     32'h0,         1'b0, 1); applyStimulus(2'd0, 1'b1, 32'h0,      32'h7777_0000, 4'hF);
      expectResp("er_rdRange", 32'h0,         1'b1, 1); applyStimulus(2'd0, 1'b0, 32'h1000,   32'h0,         4'hF);
      expectResp("er_rdAlign", 32'h0,         1'b1, 1); applyStimulus(2'd0, 1'b0, 32'h2,      32'h0,         4'hF);
      expectResp("er_wrRange", 32'h0,         1'b1, 1); applyStimulus(2'd0, 1'b1, 32'h1000,   32'hFFFF_FFFF, 4'hF);
      expectResp("er_rd0",     32'h7777_0000, 1'b0, 1); applyStimulus(2'd0, 1'b0, 32'h0,      32'h0,         4'hF);
      expectResp("er_rdBelow", 32'h0,         1'b1, 3); applyStimulus(2'd1, 1'b0, 32'hFFFC,   32'h0,         4'hF);
      expectResp("er_wrAbove", 32'h0,         1'b1, 6); applyStimulus(2'd1, 1'b1, B1 + 32'h2000, 32'h5555_5555, 4'hF);
      idleBus();
      while (expQ.size() > 0) begin
         exp = expQ.pop_front(); got = gotQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (got !== exp)
            $display("[TB] FAIL %s got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                     nm, got.data, got.err, got.lat, exp.data, exp.err, exp.lat);
         else passes++;
      end
   endtask

   task automatic test_abort();
      resp_t exp, got;
      string nm;
      int    seen;
      expectResp("ab_prewrite", 32'h0, 1'b0, 6);
      applyStimulus(2'd1, 1'b1, B1 + 32'h80, 32'h0ABC_0000, 4'hF);
      idleBus();
      @(posedge clk); #1;
      sel = 2'd1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = B1 + 32'h80; pwdata = 32'h1234_5678;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (2) @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (readyV[1]) seen++;
      end
      checks++;
      if (seen !== 0) $display("[TB] FAIL ab_noready got %0d PREADY cycles want 0", seen);
      else passes++;
      expectResp("ab_readback", 32'h0ABC_0000, 1'b0, 3);
      applyStimulus(2'd1, 1'b0, B1 + 32'h80, 32'h0, 4'hF);
      idleBus();
      @(posedge clk); #1;
      sel = 2'd0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (readyV[0]) seen++;
      end
      #1 psel = 1'b0; penable = 1'b0;
      checks++;
      if (seen !== 0) $display("[TB] FAIL ab_idlePenable got %0d PREADY cycles want 0", seen);
      else passes++;
      while (expQ.size() > 0) begin
         exp = expQ.pop_front(); got = gotQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (got !== exp)
            $display("[TB] FAIL %s got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                     nm, got.data, got.err, got.lat, exp.data, exp.err, exp.lat);
         else passes++;
      end
   endtask

`ifdef APB_MEM_STRB_EN
   task automatic test_strobe();
      resp_t exp, got;
      string nm;
      expectResp("st_init",   32'h0,         1'b0, 1); applyStimulus(2'd0, 1'b1, 32'h40, 32'h1122_3344, 4'hF);
      expectResp("st_wr0101", 32'h0,         1'b0, 1); applyStimulus(2'd0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101);
      expectResp("st_rd1",    32'h11BB_33DD, 1'b0, 1); applyStimulus(2'd0, 1'b0, 32'h40, 32'h0,         4'hF);
      expectResp("st_wrNone", 32'h0,         1'b0, 1); applyStimulus(2'd0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000);
      expectResp("st_rd2",    32'h11BB_33DD, 1'b0, 1); applyStimulus(2'd0, 1'b0, 32'h40, 32'h0,         4'hF);
      idleBus();
      while (expQ.size() > 0) begin
         exp = expQ.pop_front(); got = gotQ.pop_front(); nm = nameQ.pop_front();
         checks++;
         if (got !== exp)
            $display("[TB] FAIL %s got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                     nm, got.data, got.err, got.lat, exp.data, exp.err, exp.lat);
         else passes++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_zero_wait();
      test_back_to_back();
      test_errors();
      test_abort();
`ifdef APB_MEM_STRB_EN
      test_strobe();
`endif
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
